// File: rtl/muldiv_seq.sv
// Iterative shift-add multiply / restoring unsigned divide; WIDTH+1 cycles start-to-DoneM, 2 for divide-by-zero.
// Holds the pipeline with StallMD from the accept cycle through RUN; starts while running are ignored, FlushE aborts.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             StallMD,
    output logic             DoneM,
    output logic [WIDTH-1:0] ResultM,
    output logic             DivZeroM
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             op_div;
    logic             op_mod;

    logic             accept;
    logic             div_zero;
    logic             last_step;

    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_b;
    logic             step_div;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH:0]   nxt_acc;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;
    logic [WIDTH-1:0] result_sel;

    assign accept    = StartE & ~FlushE & (state != S_RUN);
    assign div_zero  = ((OpE == 2'b01) || (OpE == 2'b10)) && (SrcBE == '0);
    assign last_step = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
    assign StallMD   = (state == S_RUN) | accept;
    assign DoneM     = (state == S_DONE);

    // The first iteration runs on the accept edge straight from the input operands,
    // so only WIDTH-1 RUN cycles remain and DoneM lands WIDTH cycles after the start.
    always_comb begin
        step_acc = acc;
        step_a   = opa;
        step_b   = opb;
        step_div = op_div | op_mod;
        if (accept) begin
            step_acc = '0;
            step_a   = SrcAE;
            step_b   = SrcBE;
            step_div = (OpE == 2'b01) || (OpE == 2'b10);
        end

        rem_sh = {step_acc, step_a[WIDTH-1]};
        diff   = rem_sh - {2'b00, step_b};
        ge     = ~diff[WIDTH+1];

        if (step_div) begin
            nxt_acc = ge ? diff[WIDTH:0] : rem_sh[WIDTH:0];
            nxt_a   = {step_a[WIDTH-2:0], ge};
            nxt_b   = step_b;
        end else begin
            nxt_acc = step_b[0] ? step_acc + {1'b0, step_a} : step_acc;
            nxt_a   = step_a << 1;
            nxt_b   = step_b >> 1;
        end

        result_sel = op_div ? nxt_a : nxt_acc[WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        if (FlushE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_RUN:   state_nxt = last_step ? S_DONE : S_RUN;
                default: begin
                    if (accept) state_nxt = div_zero ? S_DONE : S_RUN;
                    else        state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            op_div   <= 1'b0;
            op_mod   <= 1'b0;
            ResultM  <= '0;
            DivZeroM <= 1'b0;
        end else if (accept) begin
            op_div <= (OpE == 2'b01);
            op_mod <= (OpE == 2'b10);
            if (div_zero) begin
                ResultM  <= (OpE == 2'b01) ? '1 : SrcAE;
                DivZeroM <= 1'b1;
                acc      <= '0;
                opa      <= SrcAE;
                opb      <= SrcBE;
                cnt      <= '0;
            end else begin
                acc <= nxt_acc;
                opa <= nxt_a;
                opb <= nxt_b;
                cnt <= CW'(1);
            end
        end else if ((state == S_RUN) && !FlushE) begin
            acc <= nxt_acc;
            opa <= nxt_a;
            opb <= nxt_b;
            cnt <= cnt + CW'(1);
            if (last_step) begin
                ResultM  <= result_sel;
                DivZeroM <= 1'b0;
            end
        end
    end
endmodule
